// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches, queues the returned instructions
// for decode, and handles branch redirects by flushing the queue and dropping stale responses.
//
// state | meaning
// IDLE  | one cycle after reset before fetching starts
// FETCH | normal operation, requests issued while credit is available
// FLUSH | redirect taken, discarding responses from requests issued before it
module fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             PCsrc,
    input  logic [WIDTH-1:0] ImmOp,
    input  logic [WIDTH-1:0] branch_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [WIDTH-1:0] ALIGN_MASK = {{(WIDTH-2){1'b1}}, 2'b00};
    localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
    localparam logic [CW:0]      CREDIT_MAX = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
    localparam logic [PW-1:0]    PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [PW-1:0]    PTR_ONE    = PW'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]       state;
    logic [1:0]       stateNext;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] target;

    logic [CW-1:0]    outCnt;
    logic [CW-1:0]    outNext;
    logic [CW-1:0]    dropCnt;
    logic [CW-1:0]    bufCnt;

    logic [WIDTH-1:0] bufData [DEPTH];
    logic [WIDTH-1:0] bufAddr [DEPTH];
    logic [PW-1:0]    bufRd;
    logic [PW-1:0]    bufWr;

    logic [WIDTH-1:0] flightAddr [DEPTH];
    logic [PW-1:0]    flightRd;
    logic [PW-1:0]    flightWr;

    logic             redirect;
    logic             accept;
    logic             rspValid;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] rspAddr;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign redirect = PCsrc && (state != IDLE);
    assign target   = (branch_pc + ImmOp) & ALIGN_MASK;

    // Credit counts both buffered and in-flight instructions so a response always has a slot.
    assign imem_req  = (state == FETCH) && !PCsrc &&
                       (({1'b0, bufCnt} + {1'b0, outCnt}) < CREDIT_MAX);
    assign imem_addr = pc;
    assign accept    = imem_req && imem_gnt;

    // A response with nothing outstanding is stray; ignore it rather than corrupt the counters.
    assign rspValid  = imem_rvalid && (outCnt != '0);
    assign rspAddr   = flightAddr[flightRd];

    assign push = rspValid && (dropCnt == '0) && !redirect;
    assign pop  = instr_valid && instr_ready && !redirect;

    assign instr_valid = (bufCnt != '0);
    assign instr       = bufData[bufRd];
    assign instr_pc    = bufAddr[bufRd];

    always_comb begin
        outNext = outCnt;
        if (accept && !rspValid) begin
            outNext = outCnt + CNT_ONE;
        end else if (!accept && rspValid) begin
            outNext = outCnt - CNT_ONE;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  stateNext = FETCH;
            FETCH: begin
                if (redirect) begin
                    stateNext = (outNext != '0) ? FLUSH : FETCH;
                end
            end
            FLUSH: begin
                if ((dropCnt == '0) || (rspValid && (dropCnt == CNT_ONE))) begin
                    stateNext = FETCH;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC & ALIGN_MASK;
        end else begin
            state <= stateNext;
            if (redirect) begin
                pc <= target;
            end else if (accept) begin
                pc <= pc + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outCnt  <= '0;
            dropCnt <= '0;
        end else begin
            outCnt <= outNext;
            // A second redirect while flushing must not reload the drop count: the
            // requests still owed are exactly the ones already being dropped.
            if (state == FLUSH) begin
                if (rspValid && (dropCnt != '0)) begin
                    dropCnt <= dropCnt - CNT_ONE;
                end
            end else if (redirect) begin
                dropCnt <= outNext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flightRd <= '0;
            flightWr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                flightAddr[i] <= '0;
            end
        end else begin
            if (accept) begin
                flightAddr[flightWr] <= pc;
                flightWr             <= nextPtr(flightWr);
            end
            if (rspValid) begin
                flightRd <= nextPtr(flightRd);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bufRd  <= '0;
            bufWr  <= '0;
            bufCnt <= '0;
        end else if (redirect) begin
            bufRd  <= '0;
            bufWr  <= '0;
            bufCnt <= '0;
        end else begin
            if (push) begin
                bufWr <= nextPtr(bufWr);
            end
            if (pop) begin
                bufRd <= nextPtr(bufRd);
            end
            if (push && !pop) begin
                bufCnt <= bufCnt + CNT_ONE;
            end else if (!push && pop) begin
                bufCnt <= bufCnt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                bufData[i] <= '0;
                bufAddr[i] <= '0;
            end
        end else if (push) begin
            bufData[bufWr] <= imem_rdata;
            bufAddr[bufWr] <= rspAddr;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (bufCnt == CW'(DEPTH))))
        else $error("fetch_unit: instruction buffer overflow");

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning address/instruction/immediate width.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 2, meaning instruction buffer entries and maximum (buffered + in-flight) instructions.
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports named clk and rst_n.
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 imem_req  output  1  fetch request valid.
REQ-008 imem_addr  output  WIDTH  fetch address, bits [1:0] always 00.
REQ-009 imem_gnt  input  1  memory accepts request this cycle.
REQ-010 imem_rvalid  input  1  instruction response valid; responses return in order, one or more cycles after grant.
REQ-011 imem_rdata  input  WIDTH  instruction response data.
REQ-012 instr  output  WIDTH  instruction to decode (drives sign_extend instr input).
REQ-013 instr_pc  output  WIDTH  address of instr.
REQ-014 instr_valid  output  1  instr/instr_pc valid.
REQ-015 instr_ready  input  1  decode consumes instr this cycle.
REQ-016 PCsrc  input  1  branch taken; redirect this cycle.
REQ-017 ImmOp  input  WIDTH  sign-extended branch offset from sign_extend.
REQ-018 branch_pc  input  WIDTH  address of the branch instruction.

Function
REQ-019 SHALL implement states IDLE, FETCH, FLUSH; IDLE -> FETCH unconditionally after one cycle.
REQ-020 SHALL drive imem_req high only in FETCH, PCsrc low, and (buffer count + outstanding) < DEPTH.
REQ-021 SHALL treat imem_req and imem_gnt both high as an accepted request: PC <= PC + 4 (modulo 2^WIDTH, 0xFFFFFFFC wraps to 0x0), outstanding increments.
REQ-022 SHALL decrement outstanding on every imem_rvalid; simultaneous grant and rvalid leave it unchanged.
REQ-023 SHALL push {imem_rdata, its address} into the buffer on imem_rvalid when drop count is 0; the address is tracked per in-flight request in order.
REQ-024 SHALL present the buffer head on instr/instr_pc with instr_valid = buffer non-empty; no bypass, so a response is visible the cycle after imem_rvalid.
REQ-025 SHALL pop the head when instr_valid and instr_ready; simultaneous push and pop keep the count unchanged.
REQ-026 SHALL hold instr/instr_pc stable while instr_valid high and instr_ready low.
REQ-027 On PCsrc high (any state except IDLE), SHALL set PC <= (branch_pc + ImmOp) with bits [1:0] cleared, empty the buffer, ignore any pop, and discard any response arriving that cycle.
REQ-028 On redirect, SHALL load drop count with outstanding after that cycle's rvalid decrement; next state FLUSH if nonzero, else FETCH.
REQ-029 In FLUSH, SHALL discard each response and decrement drop count; FLUSH -> FETCH on the cycle drop count reaches 0.
REQ-030 A redirect in FLUSH SHALL update PC only; drop count continues per REQ-029.
REQ-031 Buffer overflow SHALL be impossible by REQ-020; a push into a full buffer is a design error flagged by a simulation assertion.
REQ-032 Minimum latency with imem_gnt=1 and rvalid one cycle later: request at cycle t, instr_valid at t+2; sustained throughput one instruction/cycle needs DEPTH >= 2.

Reset
REQ-033 While rst_n low: PC = RESET_PC, state IDLE, buffer empty, outstanding 0, drop count 0.
REQ-034 During reset: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-035 Reset asserted mid-operation SHALL immediately abandon in-flight requests; responses returning after deassertion are the environment's responsibility to suppress.

Verification
REQ-036 Reset release, gnt=1, rvalid one cycle after each grant, ready=1 -> first request addr 0x0 two cycles after release; instr_pc sequence 0x0,0x4,0x8 at one per cycle.
REQ-037 ready=0 for 10 cycles -> at most 2 requests accepted, instr/instr_pc stable, imem_req low until a pop.
REQ-038 PCsrc=1, branch_pc=0x100, ImmOp=0xFFFFFFF0 with 2 outstanding -> next request addr 0xF0; both stale responses dropped; next instr_pc 0xF0.
REQ-039 PC=0xFFFFFFFC granted -> next imem_addr 0x0.
REQ-040 ImmOp=0x6, branch_pc=0x20 -> fetch from 0x24.
REQ-041 rst_n low during FLUSH with outstanding 1 -> outputs at reset values immediately; after release fetch restarts at RESET_PC.
